// File: rtl/hdmi_period_ctrl_if.sv
// Pixel-domain bundle between sync, hdmi_period_ctrl and the three TMDS encoders.
interface hdmi_period_ctrl_if;
  logic        de_in;
  logic [1:0]  vh_in;
  logic [23:0] pix_in;
  logic [1:0]  mode;
  logic [1:0]  vh_out;
  logic [3:0]  ctl_out;
  logic [23:0] pix_out;
  logic        de_out;
  logic        err_gap;

  modport master (
    output de_in, vh_in, pix_in,
    input  mode, vh_out, ctl_out, pix_out, de_out, err_gap
  );

  modport slave (
    input  de_in, vh_in, pix_in,
    output mode, vh_out, ctl_out, pix_out, de_out, err_gap
  );
endinterface

// File: rtl/hdmi_period_ctrl.sv
// HDMI period scheduler: delays pixel/sync/DE by LEAD clocks and marks preamble/guard/video slots.
// Define HDMI_MODE_EN for HDMI periods; undefined builds a plain DVI pass-through (CTRL/VIDEO only).
module hdmi_period_ctrl #(
  parameter int unsigned LEAD    = 10,
  parameter int unsigned MIN_GAP = 12
) (
  input logic               clk,
  input logic               rst_n,
  hdmi_period_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    M_CTRL     = 2'd0,
    M_PREAMBLE = 2'd1,
    M_GUARD    = 2'd2,
    M_VIDEO    = 2'd3
  } mode_e;

  if (LEAD != 10 || MIN_GAP < 1 || MIN_GAP > 15) begin : g_bad_params
    $error("hdmi_period_ctrl: unsupported LEAD/MIN_GAP");
  end

  logic [LEAD-1:0] de_dl;
  logic [1:0]      vh_dl  [LEAD];
  logic [23:0]     pix_dl [LEAD];
  logic            de_d;

  assign de_d = de_dl[LEAD-1];

  // LEAD stages plus the output register: a sample taken at edge n appears after edge n+LEAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_dl <= '0;
      for (int unsigned i = 0; i < LEAD; i++) begin
        vh_dl[i]  <= '0;
        pix_dl[i] <= '0;
      end
      bus.vh_out  <= '0;
      bus.pix_out <= '0;
    end else begin
      de_dl     <= {de_dl[LEAD-2:0], bus.de_in};
      vh_dl[0]  <= bus.vh_in;
      pix_dl[0] <= bus.pix_in;
      for (int unsigned i = 1; i < LEAD; i++) begin
        vh_dl[i]  <= vh_dl[i-1];
        pix_dl[i] <= pix_dl[i-1];
      end
      bus.vh_out  <= vh_dl[LEAD-1];
      bus.pix_out <= pix_dl[LEAD-1];
    end
  end

`ifdef HDMI_MODE_EN
  typedef enum logic [1:0] {
    S_CTRL,
    S_PREAMBLE,
    S_GUARD,
    S_VIDEO
  } state_e;

  localparam logic [3:0] GAP_MIN = 4'(MIN_GAP);

  state_e     state, state_nx;
  mode_e      mode_nx;
  logic [2:0] ph, ph_nx;
  logic [3:0] gap;
  logic       de_prev;
  logic       rise;
  logic       gap_ok;

  assign rise   = bus.de_in & ~de_prev;
  assign gap_ok = (gap >= GAP_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_CTRL;
      ph          <= '0;
      gap         <= '1;
      de_prev     <= 1'b0;
      bus.mode    <= M_CTRL;
      bus.de_out  <= 1'b0;
      bus.ctl_out <= '0;
      bus.err_gap <= 1'b0;
    end else begin
      state       <= state_nx;
      ph          <= ph_nx;
      de_prev     <= bus.de_in;
      gap         <= bus.de_in ? 4'd0 : ((gap == 4'hF) ? gap : gap + 4'd1);
      bus.mode    <= mode_nx;
      bus.de_out  <= (mode_nx == M_VIDEO);
      bus.ctl_out <= (state_nx == S_PREAMBLE) ? 4'b0001 : 4'b0000;
      // Short-gap rises are flagged in any state; only CTRL ever acts on a rise.
      bus.err_gap <= rise & ~gap_ok;
    end
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    unique case (state)
      S_CTRL: begin
        if (rise && gap_ok) begin
          state_nx = S_PREAMBLE;
          ph_nx    = '0;
        end
      end
      S_PREAMBLE: begin
        if (ph == 3'd7) begin
          state_nx = S_GUARD;
          ph_nx    = '0;
        end else begin
          ph_nx = ph + 3'd1;
        end
      end
      S_GUARD: begin
        if (ph == 3'd1) begin
          state_nx = S_VIDEO;
          ph_nx    = '0;
        end else begin
          ph_nx = ph + 3'd1;
        end
      end
      S_VIDEO: begin
        if (!de_d) state_nx = S_CTRL;
      end
      default: state_nx = S_CTRL;
    endcase

    // Rejected lines still show as video whenever delayed DE is high outside preamble/guard.
    mode_nx = de_d ? M_VIDEO : M_CTRL;
    if (state_nx == S_PREAMBLE)   mode_nx = M_PREAMBLE;
    else if (state_nx == S_GUARD) mode_nx = M_GUARD;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mode    <= M_CTRL;
      bus.de_out  <= 1'b0;
      bus.ctl_out <= '0;
      bus.err_gap <= 1'b0;
    end else begin
      bus.mode    <= de_d ? M_VIDEO : M_CTRL;
      bus.de_out  <= de_d;
      bus.ctl_out <= '0;
      bus.err_gap <= 1'b0;
    end
  end
`endif

endmodule
